// File: rtl/radio_rx_decim_avg.sv
// RX front-end boxcar averager: sums 2^L I/Q samples and emits their floor mean
// with a one-cycle strobe. L is programmed over the settings bus.
module radio_rx_decim_avg #(
  parameter logic [7:0]  SR_DECIM_LOG2 = 8'd200,
  parameter int unsigned MAX_LOG2      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        run,
  input  logic [31:0] in_sample,
  input  logic        in_stb,
  output logic [31:0] out_sample,
  output logic        out_stb,
  output logic [2:0]  decim_log2
);

  localparam int unsigned AccW = 16 + MAX_LOG2;
  localparam int unsigned CntW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  logic signed [AccW-1:0] acc_i_q, acc_q_q;
  logic signed [AccW-1:0] sum_i, sum_q;
  logic signed [AccW-1:0] ext_i, ext_q;
  logic [15:0]            avg_i, avg_q;
  logic [CntW-1:0]        cnt_q, cnt_last;
  logic [CntW:0]          grp_size, grp_last;
  logic [2:0]             decim_log2_q, wr_log2;
  logic [31:0]            out_sample_q;
  logic                   out_stb_q;
  logic                   rate_wr, flush;
  logic                   unused_set_data;

  assign rate_wr = set_stb && (set_addr == SR_DECIM_LOG2);
  // Any rate change, clear or idle period restarts the group so output cadence
  // always lines up with the first accepted sample afterwards.
  assign flush   = clear || rate_wr || !run;

  assign wr_log2 = (32'(set_data[2:0]) > MAX_LOG2) ? 3'(MAX_LOG2) : set_data[2:0];
  assign unused_set_data = ^set_data[31:3];

  assign grp_size = (CntW + 1)'(1) << decim_log2_q;
  assign grp_last = grp_size - 1'b1;
  assign cnt_last = grp_last[CntW-1:0];

  assign ext_i = {{MAX_LOG2{in_sample[31]}}, in_sample[31:16]};
  assign ext_q = {{MAX_LOG2{in_sample[15]}}, in_sample[15:0]};
  assign sum_i = acc_i_q + ext_i;
  assign sum_q = acc_q_q + ext_q;

  // Arithmetic shift gives floor rounding; the mean always fits in 16 bits.
  assign avg_i = 16'(sum_i >>> decim_log2_q);
  assign avg_q = 16'(sum_q >>> decim_log2_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      cnt_q        <= '0;
      decim_log2_q <= '0;
      out_sample_q <= '0;
      out_stb_q    <= 1'b0;
    end else if (flush) begin
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      cnt_q     <= '0;
      out_stb_q <= 1'b0;
      if (rate_wr) begin
        decim_log2_q <= wr_log2;
      end
    end else if (in_stb) begin
      if (cnt_q == cnt_last) begin
        out_sample_q <= {avg_i, avg_q};
        out_stb_q    <= 1'b1;
        acc_i_q      <= '0;
        acc_q_q      <= '0;
        cnt_q        <= '0;
      end else begin
        acc_i_q   <= sum_i;
        acc_q_q   <= sum_q;
        cnt_q     <= cnt_q + 1'b1;
        out_stb_q <= 1'b0;
      end
    end else begin
      out_stb_q <= 1'b0;
    end
  end

  assign out_sample = out_sample_q;
  assign out_stb    = out_stb_q;
  assign decim_log2 = decim_log2_q;

endmodule

// File: tb/tb_radio_rx_decim_avg.sv
// Bench for radio_rx_decim_avg: directed vector table, long-group sequences and
// randomized traffic checked against a queue-based mean model.
module tb_radio_rx_decim_avg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        run = 1'b0;
  logic [31:0] in_sample = 32'd0;
  logic        in_stb = 1'b0;
  logic [31:0] out_sample;
  logic        out_stb;
  logic [2:0]  decim_log2;

  int checks = 0;
  int errors = 0;

  radio_rx_decim_avg #(
    .SR_DECIM_LOG2(8'd200),
    .MAX_LOG2     (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .run       (run),
    .in_sample (in_sample),
    .in_stb    (in_stb),
    .out_sample(out_sample),
    .out_stb   (out_stb),
    .decim_log2(decim_log2)
  );

  always #5 clk = ~clk;

  // Reference model: accepted samples are queued; a full group of 2^L is averaged
  // with integer floor division.
  int          m_l = 0;
  int          m_qi[$];
  int          m_qq[$];
  logic [31:0] m_out = 32'd0;
  logic        m_stb = 1'b0;

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic ru, input logic ss,
                            input logic [7:0] a, input logic [31:0] d, input logic st,
                            input logic [31:0] s);
    int n, si, sq, mi, mq;
    logic [15:0] hi, lo;
    if (r) begin
      m_l = 0; m_qi.delete(); m_qq.delete(); m_out = 32'd0; m_stb = 1'b0;
    end else if (c || !ru || (ss && a == 8'd200)) begin
      m_qi.delete(); m_qq.delete(); m_stb = 1'b0;
      if (ss && a == 8'd200) m_l = int'(d[2:0]);
    end else if (st) begin
      m_qi.push_back(int'($signed(s[31:16])));
      m_qq.push_back(int'($signed(s[15:0])));
      n = 1 << m_l;
      m_stb = 1'b0;
      if (m_qi.size() == n) begin
        si = 0; sq = 0;
        foreach (m_qi[k]) begin si += m_qi[k]; sq += m_qq[k]; end
        mi = floor_div(si, n);
        mq = floor_div(sq, n);
        hi = 16'(mi);
        lo = 16'(mq);
        m_out = {hi, lo};
        m_stb = 1'b1;
        m_qi.delete(); m_qq.delete();
      end
    end else begin
      m_stb = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare 1 ns after the edge.
  task automatic cyc(input logic r, input logic c, input logic ru, input logic ss,
                     input logic [7:0] a, input logic [31:0] d, input logic st,
                     input logic [31:0] s);
    reset = r; clear = c; run = ru; set_stb = ss; set_addr = a; set_data = d;
    in_stb = st; in_sample = s;
    model_step(r, c, ru, ss, a, d, st, s);
    @(posedge clk);
    #1;
    chk("model_stb", {31'd0, out_stb}, {31'd0, m_stb});
    chk("model_sample", out_sample, m_out);
    chk("model_log2", {29'd0, decim_log2}, m_l[31:0]);
  endtask

  typedef struct {
    logic        rst, clr, run, sstb;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        stb;
    logic [31:0] smp;
    logic        exp_stb;
    logic [31:0] exp_smp;
    logic [2:0]  exp_l;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic c, input logic ru, input logic ss,
                              input logic [7:0] a, input logic [31:0] d, input logic st,
                              input logic [31:0] s, input logic es, input logic [31:0] esm,
                              input logic [2:0] el);
    vec_t v;
    v.rst = r; v.clr = c; v.run = ru; v.sstb = ss; v.addr = a; v.wdata = d;
    v.stb = st; v.smp = s; v.exp_stb = es; v.exp_smp = esm; v.exp_l = el;
    return v;
  endfunction

  // Plain sample and idle cycles with run high.
  function automatic vec_t smp(input logic [31:0] s, input logic es, input logic [31:0] esm,
                               input logic [2:0] el);
    return mk(0, 0, 1, 0, 8'd0, 32'd0, 1, s, es, esm, el);
  endfunction

  function automatic vec_t idl(input logic [31:0] esm, input logic [2:0] el);
    return mk(0, 0, 1, 0, 8'd0, 32'd0, 0, 32'd0, 0, esm, el);
  endfunction

  function automatic vec_t wr(input logic [31:0] d, input logic st, input logic [31:0] s,
                              input logic [31:0] esm, input logic [2:0] el);
    return mk(0, 0, 1, 1, 8'd200, d, st, s, 0, esm, el);
  endfunction

  initial begin
    int n_stb;
    logic last_hit;
    logic [31:0] rs;

    // Reset, L=0 bypass
    vecs.push_back(mk(1, 0, 1, 0, 8'd0, 32'd0, 0, 32'd0, 0, 32'd0, 0));
    vecs.push_back(idl(32'd0, 0));
    vecs.push_back(smp(32'h0001_0002, 1, 32'h0001_0002, 0));
    vecs.push_back(smp(32'hFFFF_8000, 1, 32'hFFFF_8000, 0));
    vecs.push_back(idl(32'hFFFF_8000, 0));
    // L=2, I = 4,8,12,16 spaced three cycles
    vecs.push_back(wr(32'hFFFF_FFFA, 0, 32'd0, 32'hFFFF_8000, 2));
    vecs.push_back(smp(32'h0004_0000, 0, 32'hFFFF_8000, 2));
    vecs.push_back(idl(32'hFFFF_8000, 2));
    vecs.push_back(idl(32'hFFFF_8000, 2));
    vecs.push_back(smp(32'h0008_0000, 0, 32'hFFFF_8000, 2));
    vecs.push_back(idl(32'hFFFF_8000, 2));
    vecs.push_back(idl(32'hFFFF_8000, 2));
    vecs.push_back(smp(32'h000C_0000, 0, 32'hFFFF_8000, 2));
    vecs.push_back(idl(32'hFFFF_8000, 2));
    vecs.push_back(idl(32'hFFFF_8000, 2));
    vecs.push_back(smp(32'h0010_0000, 1, 32'h000A_0000, 2));
    vecs.push_back(idl(32'h000A_0000, 2));
    // L=1 floor rounding on both rails
    vecs.push_back(wr(32'd1, 0, 32'd0, 32'h000A_0000, 1));
    vecs.push_back(smp(32'hFFFF_0000, 0, 32'h000A_0000, 1));
    vecs.push_back(smp(32'hFFFE_0000, 1, 32'hFFFE_0000, 1));
    vecs.push_back(smp(32'h0001_0000, 0, 32'hFFFE_0000, 1));
    vecs.push_back(smp(32'h0002_0000, 1, 32'h0001_0000, 1));
    vecs.push_back(smp(32'h0000_FFFF, 0, 32'h0001_0000, 1));
    vecs.push_back(smp(32'h0000_0000, 1, 32'h0000_FFFF, 1));
    // Write to another address is ignored and the sample is accepted
    vecs.push_back(mk(0, 0, 1, 1, 8'd201, 32'd0, 1, 32'h0004_0004, 0, 32'h0000_FFFF, 1));
    vecs.push_back(smp(32'h0002_0002, 1, 32'h0003_0003, 1));
    // L=2: run low drops partial group and the coinciding sample
    vecs.push_back(wr(32'd2, 0, 32'd0, 32'h0003_0003, 2));
    for (int i = 0; i < 3; i++) vecs.push_back(smp(32'h0001_0001, 0, 32'h0003_0003, 2));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0, 32'd0, 1, 32'h7FFF_7FFF, 0, 32'h0003_0003, 2));
    for (int i = 0; i < 3; i++) vecs.push_back(smp(32'h0064_0000, 0, 32'h0003_0003, 2));
    vecs.push_back(smp(32'h0064_0000, 1, 32'h0064_0000, 2));
    // Clear
    for (int i = 0; i < 3; i++) vecs.push_back(smp(32'h0001_0001, 0, 32'h0064_0000, 2));
    vecs.push_back(mk(0, 1, 1, 0, 8'd0, 32'd0, 1, 32'h7FFF_7FFF, 0, 32'h0064_0000, 2));
    for (int i = 0; i < 3; i++) vecs.push_back(smp(32'h0002_0002, 0, 32'h0064_0000, 2));
    vecs.push_back(smp(32'h0002_0002, 1, 32'h0002_0002, 2));
    // Rate write coinciding with in_stb
    for (int i = 0; i < 3; i++) vecs.push_back(smp(32'h0003_0003, 0, 32'h0002_0002, 2));
    vecs.push_back(wr(32'd2, 1, 32'h7FFF_7FFF, 32'h0002_0002, 2));
    for (int i = 0; i < 3; i++) vecs.push_back(smp(32'hFFFC_FFFC, 0, 32'h0002_0002, 2));
    vecs.push_back(smp(32'hFFFC_FFFC, 1, 32'hFFFC_FFFC, 2));
    // Reset mid-group, then bypass
    vecs.push_back(smp(32'h0005_0005, 0, 32'hFFFC_FFFC, 2));
    vecs.push_back(smp(32'h0005_0005, 0, 32'hFFFC_FFFC, 2));
    vecs.push_back(mk(1, 0, 1, 0, 8'd0, 32'd0, 0, 32'd0, 0, 32'd0, 0));
    vecs.push_back(smp(32'h1234_5678, 1, 32'h1234_5678, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].clr, vecs[i].run, vecs[i].sstb, vecs[i].addr,
          vecs[i].wdata, vecs[i].stb, vecs[i].smp);
      chk($sformatf("vec%0d_stb", i), {31'd0, out_stb}, {31'd0, vecs[i].exp_stb});
      chk($sformatf("vec%0d_sample", i), out_sample, vecs[i].exp_smp);
      chk($sformatf("vec%0d_log2", i), {29'd0, decim_log2}, {29'd0, vecs[i].exp_l});
    end

    // L=7 full-scale groups: exactly one strobe on the 128th sample
    cyc(0, 0, 1, 1, 8'd200, 32'd7, 0, 32'd0);
    chk("l7_log2", {29'd0, decim_log2}, 32'd7);
    n_stb = 0; last_hit = 1'b0;
    for (int i = 0; i < 128; i++) begin
      cyc(0, 0, 1, 0, 8'd0, 32'd0, 1, 32'h7FFF_7FFF);
      if (out_stb) n_stb++;
      if (i == 127) last_hit = out_stb;
    end
    chk("l7_pos_count", n_stb, 32'd1);
    chk("l7_pos_last", {31'd0, last_hit}, 32'd1);
    chk("l7_pos_value", out_sample, 32'h7FFF_7FFF);
    n_stb = 0; last_hit = 1'b0;
    for (int i = 0; i < 128; i++) begin
      cyc(0, 0, 1, 0, 8'd0, 32'd0, 1, 32'h8000_8000);
      if (out_stb) n_stb++;
      if (i == 127) last_hit = out_stb;
      cyc(0, 0, 1, 0, 8'd0, 32'd0, 0, 32'd0);
      if (out_stb) n_stb++;
    end
    chk("l7_neg_count", n_stb, 32'd1);
    chk("l7_neg_last", {31'd0, last_hit}, 32'd1);
    chk("l7_neg_value", out_sample, 32'h8000_8000);

    // Randomized traffic against the model
    for (int i = 0; i < 8000; i++) begin
      rs = $urandom;
      if ($urandom_range(0, 7) == 0) rs = $urandom_range(0, 1) ? 32'h7FFF_7FFF : 32'h8000_8000;
      cyc($urandom_range(0, 1999) == 0,
          $urandom_range(0, 499) == 0,
          $urandom_range(0, 499) != 0,
          $urandom_range(0, 399) == 0,
          $urandom_range(0, 3) == 0 ? 8'd199 : 8'd200,
          $urandom,
          $urandom_range(0, 2) != 0,
          rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
